// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data memory between the CPU path (A)
// and the DMA/host loader (B). A has priority; a starvation counter forces a
// B slot after MAX_WAIT consecutive lost cycles. Read returns are steered to
// the owning port with a registered single-cycle valid.
module dmem_arbiter #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_req,
  input  logic             a_we,
  input  logic [WIDTH-1:0] a_addr,
  input  logic [31:0]      a_wdata,
  input  logic             b_req,
  input  logic             b_we,
  input  logic [WIDTH-1:0] b_addr,
  input  logic [31:0]      b_wdata,
  output logic             a_gnt,
  output logic             b_gnt,
  output logic             a_rvalid,
  output logic             b_rvalid,
  output logic [31:0]      a_rdata,
  output logic [31:0]      b_rdata,
  output logic [WIDTH-1:0] mem_address,
  output logic [31:0]      mem_data_in,
  output logic             mem_write,
  output logic             mem_read,
  input  logic [31:0]      mem_data_out,
  input  logic             mem_stall
);

  localparam int unsigned CNT_W   = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] WAIT_TH = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             rd_pend;
  logic             rd_port;
  logic             stall_q;
  logic             gnt_ok;
  logic             sel_we;
  logic             rd_pend_nxt;
  logic             rd_port_nxt;

  // Return data is the memory's registered output, shared by both ports.
  assign a_rdata = mem_data_out;
  assign b_rdata = mem_data_out;

  // Grant selection, memory drive and next read-tag computation.
  always_comb begin
    a_gnt       = 1'b0;
    b_gnt       = 1'b0;
    // The cycle after a stall re-presents a held read return; no new grant then.
    gnt_ok      = rst_n & ~mem_stall & ~(stall_q & rd_pend);
    if (gnt_ok) begin
      if (b_req && (starve_cnt >= WAIT_TH)) begin
        b_gnt = 1'b1;
      end else if (a_req) begin
        a_gnt = 1'b1;
      end else if (b_req) begin
        b_gnt = 1'b1;
      end
    end

    mem_address = b_gnt ? b_addr  : a_addr;
    mem_data_in = b_gnt ? b_wdata : a_wdata;
    sel_we      = b_gnt ? b_we    : a_we;
    mem_write   = (a_gnt | b_gnt) & sel_we;
    mem_read    = (a_gnt | b_gnt) & ~sel_we;

    rd_pend_nxt = rd_pend;
    rd_port_nxt = rd_port;
    if (!mem_stall) begin
      rd_pend_nxt = mem_read;
      rd_port_nxt = mem_read ? b_gnt : rd_port;
    end
  end

  // Starvation counter, read-owner tag and registered valid pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      rd_pend    <= 1'b0;
      rd_port    <= 1'b0;
      stall_q    <= 1'b0;
      a_rvalid   <= 1'b0;
      b_rvalid   <= 1'b0;
    end else begin
      stall_q <= mem_stall;
      if (!b_req || b_gnt) begin
        starve_cnt <= '0;
      end else if (!mem_stall && (starve_cnt != CNT_MAX)) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
      rd_pend  <= rd_pend_nxt;
      rd_port  <= rd_port_nxt;
      a_rvalid <= rd_pend_nxt & ~rd_port_nxt;
      b_rvalid <= rd_pend_nxt & rd_port_nxt;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: table of per-cycle vectors plus hand sequences for
// reset behaviour, with a small registered-read memory model behind the DUT.
module tb_dmem_arbiter;

  localparam logic [15:0] AD_A = 16'h000A;
  localparam logic [15:0] AD_W = 16'h0100;
  localparam logic [15:0] AD_C = 16'h0020;
  localparam logic [31:0] D_A  = 32'hDEADBEEF;
  localparam logic [31:0] D_W  = 32'h12345678;
  localparam logic [31:0] D_C  = 32'h11111111;
  localparam int NV = 23;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [15:0] a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [31:0] a_rdata, b_rdata;
  logic [15:0] mem_address;
  logic [31:0] mem_data_in, mem_data_out;
  logic        mem_write, mem_read, mem_stall;

  logic [31:0] mem [0:65535];
  logic [31:0] mem_q;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic a_req; logic a_we; logic [15:0] a_addr; logic [31:0] a_wdata;
    logic b_req; logic b_we; logic [15:0] b_addr; logic [31:0] b_wdata;
    logic stall;
    logic e_agnt; logic e_bgnt; logic e_rd; logic e_wr; logic [15:0] e_addr;
    logic e_arv; logic e_brv; logic chk; logic [31:0] e_data;
  } vec_t;

  vec_t vecs [NV];

  dmem_arbiter #(.WIDTH(16), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .a_rdata(a_rdata), .b_rdata(b_rdata),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_write(mem_write), .mem_read(mem_read),
    .mem_data_out(mem_data_out), .mem_stall(mem_stall)
  );

  always #5 clk = ~clk;

  // Single-ported memory with one-cycle registered read; frozen while stalled.
  always @(posedge clk) begin
    if (!mem_stall) begin
      if (mem_write) mem[mem_address] <= mem_data_in;
      if (mem_read)  mem_q <= mem[mem_address];
    end
  end
  assign mem_data_out = mem_q;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  task automatic idle_inputs();
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    mem_stall = 1'b0;
  endtask

  initial begin
    mem_q = '0;
    mem[AD_A] = D_A;
    mem[AD_C] = D_C;
    mem[AD_W] = 32'h0;

    // Vector table: one entry per cycle; rvalid reflects the previous cycle's grant.
    vecs[0]  = '{1,0,AD_A,0,   0,0,0,0,    0, 1,0,1,0,AD_A, 0,0,0,0};
    vecs[1]  = '{0,0,0,0,      0,0,0,0,    0, 0,0,0,0,0,    1,0,1,D_A};
    vecs[2]  = '{1,1,AD_W,D_W, 0,0,0,0,    0, 1,0,0,1,AD_W, 0,0,0,0};
    vecs[3]  = '{0,0,0,0,      1,0,AD_W,0, 0, 0,1,1,0,AD_W, 0,0,0,0};
    vecs[4]  = '{0,0,0,0,      0,0,0,0,    0, 0,0,0,0,0,    0,1,1,D_W};
    vecs[5]  = '{1,0,AD_A,0,   1,0,AD_W,0, 0, 1,0,1,0,AD_A, 0,0,0,0};
    for (int i = 6; i <= 8; i++)
      vecs[i] = '{1,0,AD_A,0,  1,0,AD_W,0, 0, 1,0,1,0,AD_A, 1,0,1,D_A};
    vecs[9]  = '{1,0,AD_A,0,   1,0,AD_W,0, 0, 0,1,1,0,AD_W, 1,0,1,D_A};
    vecs[10] = '{1,0,AD_A,0,   1,0,AD_W,0, 0, 1,0,1,0,AD_A, 0,1,1,D_W};
    for (int i = 11; i <= 13; i++)
      vecs[i] = '{1,0,AD_A,0,  1,0,AD_W,0, 0, 1,0,1,0,AD_A, 1,0,1,D_A};
    vecs[14] = '{1,0,AD_A,0,   1,0,AD_W,0, 0, 0,1,1,0,AD_W, 1,0,1,D_A};
    vecs[15] = '{0,0,0,0,      0,0,0,0,    0, 0,0,0,0,0,    0,1,1,D_W};
    vecs[16] = '{0,0,0,0,      1,0,AD_C,0, 0, 0,1,1,0,AD_C, 0,0,0,0};
    for (int i = 17; i <= 19; i++)
      vecs[i] = '{1,0,AD_A,0,  0,0,0,0,    1, 0,0,0,0,0,    0,1,0,0};
    vecs[20] = '{1,0,AD_A,0,   0,0,0,0,    0, 0,0,0,0,0,    0,1,1,D_C};
    vecs[21] = '{1,0,AD_A,0,   0,0,0,0,    0, 1,0,1,0,AD_A, 0,0,0,0};
    vecs[22] = '{0,0,0,0,      0,0,0,0,    0, 0,0,0,0,0,    1,0,1,D_A};

    // Reset held with both ports requesting reads.
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    a_req = 1'b1; a_addr = AD_A; b_req = 1'b1; b_addr = AD_W;
    #1;
    chk("rst_a_gnt", -1, 32'(a_gnt), 32'd0);
    chk("rst_b_gnt", -1, 32'(b_gnt), 32'd0);
    chk("rst_mem_read", -1, 32'(mem_read), 32'd0);
    chk("rst_a_rvalid", -1, 32'(a_rvalid), 32'd0);
    chk("rst_b_rvalid", -1, 32'(b_rvalid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_a_gnt", -1, 32'(a_gnt), 32'd1);
    chk("rel_b_gnt", -1, 32'(b_gnt), 32'd0);
    idle_inputs();

    // Table-driven cycles.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      a_req = vecs[i].a_req; a_we = vecs[i].a_we; a_addr = vecs[i].a_addr; a_wdata = vecs[i].a_wdata;
      b_req = vecs[i].b_req; b_we = vecs[i].b_we; b_addr = vecs[i].b_addr; b_wdata = vecs[i].b_wdata;
      mem_stall = vecs[i].stall;
      #1;
      chk("a_gnt", i, 32'(a_gnt), 32'(vecs[i].e_agnt));
      chk("b_gnt", i, 32'(b_gnt), 32'(vecs[i].e_bgnt));
      chk("mem_read", i, 32'(mem_read), 32'(vecs[i].e_rd));
      chk("mem_write", i, 32'(mem_write), 32'(vecs[i].e_wr));
      if (vecs[i].e_agnt || vecs[i].e_bgnt)
        chk("mem_address", i, 32'(mem_address), 32'(vecs[i].e_addr));
      if (vecs[i].e_wr)
        chk("mem_data_in", i, mem_data_in, vecs[i].a_wdata | vecs[i].b_wdata);
      chk("a_rvalid", i, 32'(a_rvalid), 32'(vecs[i].e_arv));
      chk("b_rvalid", i, 32'(b_rvalid), 32'(vecs[i].e_brv));
      if (vecs[i].chk) begin
        if (vecs[i].e_arv) chk("a_rdata", i, a_rdata, vecs[i].e_data);
        if (vecs[i].e_brv) chk("b_rdata", i, b_rdata, vecs[i].e_data);
      end
    end

    // Reset asserted in the cycle after an A read grant drops the return.
    @(negedge clk);
    idle_inputs();
    a_req = 1'b1; a_addr = AD_A;
    #1;
    chk("mid_a_gnt", 100, 32'(a_gnt), 32'd1);
    @(posedge clk);
    #1;
    chk("mid_a_rvalid_pre", 100, 32'(a_rvalid), 32'd1);
    a_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_a_rvalid_rst", 100, 32'(a_rvalid), 32'd0);
    chk("mid_b_rvalid_rst", 100, 32'(b_rvalid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("post_a_rvalid", 101 + i, 32'(a_rvalid), 32'd0);
      chk("post_b_rvalid", 101 + i, 32'(b_rvalid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
